// File: rtl/hack_pkg.sv
// Shared types for the Hack fetch path: word width, fetch FSM states and the
// {addr, data} entry carried through the instruction FIFO.
package hack_pkg;

  localparam int WORD_W = 16;

  typedef enum logic {
    FS_INIT = 1'b0,
    FS_RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Decode-side port bundle of the fetch controller: the instruction stream
// towards the CPU and the redirect request coming back from it.
interface fetch_ctrl_if #(
  parameter int WIDTH = 16
);

  // A word transfers on every rising edge where instr_valid and instr_ready
  // are both high. instr_valid never waits on instr_ready, and instr and
  // instr_addr hold steady while instr_valid is high without instr_ready.
  // A jmp_valid cycle squashes everything buffered, including a head offered
  // in that same cycle.
  logic             jmp_valid;
  logic [WIDTH-1:0] jmp_addr;
  logic             instr_valid;
  logic             instr_ready;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instr_addr;

  modport master (
    output instr_valid, instr, instr_addr,
    input  instr_ready, jmp_valid, jmp_addr
  );

  modport slave (
    input  instr_valid, instr, instr_addr,
    output instr_ready, jmp_valid, jmp_addr
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a dominant flush and an
// occupancy count; storage resets to zero so the head reads 0 after reset.
module fetch_fifo
  import hack_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  rdata,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      // Power-of-two depth lets the pointers wrap naturally.
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Hack instruction fetch controller: steers the PC, issues ROM reads, tags the
// returning words with their address and streams them to decode.
module fetch_ctrl
  import hack_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   pc_out,
  output logic [WIDTH-1:0]   pc_in,
  output logic               pc_load,
  output logic               pc_inc,
  output logic               pc_reset,
  output logic               rom_en,
  output logic [WIDTH-1:0]   rom_addr,
  input  logic [WIDTH-1:0]   rom_data,
  fetch_ctrl_if.master       dec,
  output fetch_state_t       state_dbg
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  fetch_state_t   state;
  fetch_state_t   state_nxt;
  logic           inflight;
  logic [WIDTH-1:0] tag;
  logic [CW-1:0]  count;
  logic           pop;
  logic           push;
  logic           flush;
  logic [OW-1:0]  occupancy;
  fetch_entry_t   head;
  fetch_entry_t   wentry;

  // Slots already committed once this cycle's pop is accounted for; a pop
  // only happens with count >= 1, so this never underflows.
  assign occupancy = OW'(count) + OW'(inflight) - OW'(pop);

  always_comb begin
    state_nxt = FS_RUN;
    pc_reset  = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_in     = '0;
    rom_en    = 1'b0;
    flush     = 1'b0;
    if (state == FS_INIT) begin
      pc_reset = 1'b1;
    end else if (dec.jmp_valid) begin
      pc_load = 1'b1;
      pc_in   = dec.jmp_addr;
      flush   = 1'b1;
    end else if (occupancy < OW'(DEPTH)) begin
      rom_en = 1'b1;
      pc_inc = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FS_INIT;
      inflight <= 1'b0;
      tag      <= '0;
    end else begin
      state    <= state_nxt;
      // A redirect forces rom_en low, which also drops the pending read.
      inflight <= rom_en;
      if (rom_en) tag <= pc_out;
    end
  end

  assign rom_addr  = pc_out;
  assign push      = inflight && !flush;
  assign pop       = dec.instr_valid && dec.instr_ready;
  assign wentry    = '{addr: tag, data: rom_data};
  assign state_dbg = state;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wentry),
    .rdata (head),
    .count (count)
  );

  assign dec.instr_valid = (count != '0);
  assign dec.instr       = head.data;
  assign dec.instr_addr  = head.addr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC and ROM environment, a queue-based behavioural
// model checked every cycle, an in-order stream scoreboard, and directed scenarios.
module tb_fetch_ctrl;
  import hack_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] pc_out   = 16'h5A5A;
  logic [W-1:0] rom_data = 16'h0000;
  logic [W-1:0] pc_in;
  logic [W-1:0] rom_addr;
  logic         pc_load;
  logic         pc_inc;
  logic         pc_reset;
  logic         rom_en;
  fetch_state_t state_dbg;

  fetch_ctrl_if #(.WIDTH(W)) dec_if ();

  fetch_ctrl #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_out    (pc_out),
    .pc_in     (pc_in),
    .pc_load   (pc_load),
    .pc_inc    (pc_inc),
    .pc_reset  (pc_reset),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .dec       (dec_if),
    .state_dbg (state_dbg)
  );

  function automatic logic [W-1:0] rom_word(input logic [W-1:0] a);
    return 16'h1000 + a;
  endfunction

  // Environment: PC register and synchronous ROM.
  always @(posedge clk) begin
    if (pc_reset)     pc_out <= '0;
    else if (pc_load) pc_out <= pc_in;
    else if (pc_inc)  pc_out <= pc_out + 16'd1;
  end

  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_word(rom_addr);
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: exp_q holds the buffered {addr, data} words, pend_*
  // the single outstanding ROM read, mpc the PC value the fetcher should see.
  logic         running   = 1'b0;
  logic         pend_v    = 1'b0;
  logic [W-1:0] pend_addr = '0;
  logic [W-1:0] mpc       = '0;
  logic [W-1:0] next_addr = '0;

  always @(negedge clk) begin : model
    logic         pop_m;
    logic         e_en;
    logic         e_load;
    logic [W-1:0] e_pcin;
    int           occ;
    if (!reset) begin
      running = 1'b0;
      pend_v  = 1'b0;
      next_addr = '0;
      exp_q.delete();
      chk("rst_pc_reset", pc_reset, 1);
      chk("rst_pc_load", pc_load, 0);
      chk("rst_pc_inc", pc_inc, 0);
      chk("rst_rom_en", rom_en, 0);
      chk("rst_pc_in", pc_in, 0);
      chk("rst_valid", dec_if.instr_valid, 0);
      chk("rst_instr", dec_if.instr, 0);
      chk("rst_instr_addr", dec_if.instr_addr, 0);
      chk("rst_state", state_dbg, FS_INIT);
    end else begin
      pop_m  = (exp_q.size() != 0) && dec_if.instr_ready;
      e_en   = 1'b0;
      e_load = 1'b0;
      e_pcin = '0;
      if (running && dec_if.jmp_valid) begin
        e_load = 1'b1;
        e_pcin = dec_if.jmp_addr;
      end else if (running) begin
        occ  = exp_q.size() + int'(pend_v) - int'(pop_m);
        e_en = (occ < DEPTH);
      end
      chk("state", state_dbg, running ? FS_RUN : FS_INIT);
      chk("pc_reset", pc_reset, !running);
      chk("pc_load", pc_load, e_load);
      chk("pc_in", pc_in, e_pcin);
      chk("rom_en", rom_en, e_en);
      chk("pc_inc", pc_inc, e_en);
      if (running) chk("rom_addr", rom_addr, mpc);
      chk("instr_valid", dec_if.instr_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("instr", dec_if.instr, exp_q[0][W-1:0]);
        chk("instr_addr", dec_if.instr_addr, exp_q[0][2*W-1:W]);
      end
      // Stream view: accepted words run consecutively from the last restart point.
      if (pop_m && running && !dec_if.jmp_valid) begin
        chk("stream_addr", dec_if.instr_addr, next_addr);
        chk("stream_data", dec_if.instr, rom_word(next_addr));
        next_addr = next_addr + 16'd1;
      end
      if (!running) begin
        running = 1'b1;
        mpc     = '0;
        pend_v  = 1'b0;
      end else if (dec_if.jmp_valid) begin
        exp_q.delete();
        pend_v    = 1'b0;
        mpc       = dec_if.jmp_addr;
        next_addr = dec_if.jmp_addr;
      end else begin
        if (pop_m) void'(exp_q.pop_front());
        if (pend_v) exp_q.push_back({pend_addr, rom_word(pend_addr)});
        pend_v    = e_en;
        pend_addr = mpc;
        if (e_en) mpc = mpc + 16'd1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input logic j, input logic [W-1:0] ja, input logic r);
    @(posedge clk);
    #1;
    dec_if.jmp_valid   = j;
    dec_if.jmp_addr    = ja;
    dec_if.instr_ready = r;
    #2;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic         j;
    logic [W-1:0] ja;
    dec_if.jmp_valid   = 1'b0;
    dec_if.jmp_addr    = '0;
    dec_if.instr_ready = 1'b1;
    repeat (3) @(posedge clk);

    // Cold start: cycle 0 is INIT, first word lands in cycle 3.
    release_reset();
    chk("cold_c0_pc_reset", pc_reset, 1);
    tick(0, 0, 1);
    chk("cold_c1_rom_en", rom_en, 1);
    chk("cold_c1_rom_addr", rom_addr, 16'h0000);
    tick(0, 0, 1);
    chk("cold_c2_valid", dec_if.instr_valid, 0);
    tick(0, 0, 1);
    chk("cold_c3_valid", dec_if.instr_valid, 1);
    chk("cold_c3_instr", dec_if.instr, 16'h1000);
    chk("cold_c3_addr", dec_if.instr_addr, 16'h0000);
    tick(0, 0, 1);
    chk("cold_c4_instr", dec_if.instr, 16'h1001);
    tick(0, 0, 1);
    chk("cold_c5_instr", dec_if.instr, 16'h1002);

    // Backpressure: FIFO fills and issue stops.
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("bp_rom_en", rom_en, 0);
    chk("bp_valid", dec_if.instr_valid, 1);
    tick(0, 0, 0);
    tick(0, 0, 0);
    repeat (4) tick(0, 0, 1);

    // Redirect while full with a read outstanding.
    repeat (3) tick(0, 0, 0);
    tick(1, 16'h0040, 0);
    chk("jmp_pc_load", pc_load, 1);
    chk("jmp_pc_in", pc_in, 16'h0040);
    chk("jmp_rom_en", rom_en, 0);
    tick(0, 0, 1);
    chk("jmp_j1_valid", dec_if.instr_valid, 0);
    chk("jmp_j1_rom_addr", rom_addr, 16'h0040);
    tick(0, 0, 1);
    chk("jmp_j2_valid", dec_if.instr_valid, 0);
    tick(0, 0, 1);
    chk("jmp_j3_addr", dec_if.instr_addr, 16'h0040);
    chk("jmp_j3_instr", dec_if.instr, 16'h1040);
    repeat (4) tick(0, 0, 1);

    // Redirect colliding with a pop and a push, target near the top of memory.
    tick(1, 16'hFFFE, 1);
    chk("wrap_pc_load", pc_load, 1);
    tick(0, 0, 1);
    chk("flush_valid", dec_if.instr_valid, 0);
    tick(0, 0, 1);
    tick(0, 0, 1);
    chk("wrap_j3_addr", dec_if.instr_addr, 16'hFFFE);
    tick(0, 0, 1);
    chk("wrap_j4_addr", dec_if.instr_addr, 16'hFFFF);
    tick(0, 0, 1);
    chk("wrap_j5_addr", dec_if.instr_addr, 16'h0000);
    repeat (3) tick(0, 0, 1);

    // Mid-run reset acts immediately, then cold start repeats.
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_valid", dec_if.instr_valid, 0);
    chk("midrst_pc_reset", pc_reset, 1);
    chk("midrst_state", state_dbg, FS_INIT);
    tick(0, 0, 1);
    release_reset();
    repeat (3) tick(0, 0, 1);
    chk("midrst_c3_valid", dec_if.instr_valid, 1);
    chk("midrst_c3_addr", dec_if.instr_addr, 16'h0000);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat ($urandom_range(1, 2)) tick(0, 0, 1);
        release_reset();
      end else begin
        j  = ($urandom_range(0, 19) == 0);
        ja = $urandom_range(0, 1) ? 16'($urandom) : 16'hFFF0 + 16'($urandom_range(0, 15));
        tick(j, ja, $urandom_range(0, 3) != 0);
      end
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
